// File: rtl/scalar_multiplier_v_seq.sv
// Time-multiplexed scalar x vector multiplier: MULS shared multipliers,
// signed/unsigned, optional saturation, valid/ready on both sides.
module scalar_multiplier_v_seq #(
  parameter int ELEM_W   = 32,
  parameter int LANES    = 8,
  parameter int MULS     = 2,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    signed_mode,
  input  logic [ELEM_W-1:0]       scalar,
  input  logic [LANES*ELEM_W-1:0] in_vector,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ELEM_W-1:0] out_vector,
  output logic                    overflow
);

  localparam int W     = ELEM_W;
  localparam int STEPS = LANES / MULS;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (LANES % MULS != 0) begin : g_bad_cfg
    $error("LANES must be a multiple of MULS");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        scalar_q;
  logic [LANES*W-1:0]  vec_q;
  logic [LANES*W-1:0]  res_q, res_d;
  logic                signed_q;
  logic                ovf_q, ovf_d;
  logic [CW-1:0]       cnt_q;
  logic                accept;
  logic [2*W-1:0]      ext_b;
  logic [W-1:0]        lane_res [MULS];
  logic [MULS-1:0]     lane_ovf;

  assign accept = in_valid & in_ready;
  assign ext_b  = {{W{signed_q & scalar_q[W-1]}}, scalar_q};

  // Low 2W bits of sign-extended operands give the exact signed product
  for (genvar g = 0; g < MULS; g++) begin : g_mul
    logic [W-1:0]   a;
    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] prod;
    logic [W:0]     top;
    logic [W-1:0]   sat;

    assign a     = vec_q[(int'(cnt_q) * MULS + g) * W +: W];
    assign ext_a = {{W{signed_q & a[W-1]}}, a};
    assign prod  = ext_a * ext_b;
    assign top   = prod[2*W-1:W-1];

    assign lane_ovf[g] = signed_q ? !((&top) || !(|top))
                                  : |top[W:1];
    assign sat = !signed_q ? '1
               : top[W]    ? {1'b1, {(W-1){1'b0}}}
               :             {1'b0, {(W-1){1'b1}}};
    assign lane_res[g] = (SATURATE != 0 && lane_ovf[g])
                       ? sat : prod[W-1:0];
  end

  always_comb begin
    res_d = res_q;
    ovf_d = ovf_q;
    if (accept) ovf_d = 1'b0;
    if (state_q == COMPUTE) begin
      for (int m = 0; m < MULS; m++) begin
        res_d[(int'(cnt_q) * MULS + m) * W +: W] = lane_res[m];
        ovf_d = ovf_d | lane_ovf[m];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)        state_d = COMPUTE;
      COMPUTE: if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scalar_q <= '0;
      vec_q    <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        scalar_q <= scalar;
        vec_q    <= in_vector;
        signed_q <= signed_mode;
        cnt_q    <= '0;
      end else if (state_q == COMPUTE) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_vector = res_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_scalar_multiplier_v_seq.sv
// Directed bench for scalar_multiplier_v_seq: truncate and saturate
// instances in lockstep plus a small 4x16 fully parallel instance.
module tb_scalar_multiplier_v_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         in_valid = 1'b0;
  logic         signed_mode = 1'b0;
  logic [31:0]  scalar = '0;
  logic [255:0] in_vector = '0;
  logic         out_ready = 1'b0;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [255:0] out_vec0, out_vec1;
  logic         ovf0, ovf1;

  logic         iv2 = 1'b0;
  logic         sm2 = 1'b0;
  logic [15:0]  sc2 = '0;
  logic [63:0]  vec2 = '0;
  logic         or2 = 1'b0;
  logic         ir2, ov2, ovf2;
  logic [63:0]  ovec2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scalar_multiplier_v_seq #(.SATURATE(0)) d0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .signed_mode(signed_mode), .scalar(scalar),
    .in_vector(in_vector),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_vector(out_vec0), .overflow(ovf0)
  );

  scalar_multiplier_v_seq #(.SATURATE(1)) d1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1),
    .signed_mode(signed_mode), .scalar(scalar),
    .in_vector(in_vector),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_vector(out_vec1), .overflow(ovf1)
  );

  scalar_multiplier_v_seq #(
    .ELEM_W(16), .LANES(4), .MULS(4), .SATURATE(1)
  ) d2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2),
    .signed_mode(sm2), .scalar(sc2),
    .in_vector(vec2),
    .out_valid(ov2), .out_ready(or2),
    .out_vector(ovec2), .overflow(ovf2)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_out0(output int k);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!out_valid0 && k < 20);
  endtask

  task automatic run_vec(input string tag,
                         input logic sm,
                         input logic [31:0] s,
                         input logic [255:0] v,
                         input logic [255:0] e0,
                         input logic [255:0] e1,
                         input logic eo);
    int k;
    k = 0;
    while (!in_ready0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_rdy"}, in_ready0, 1);
    in_valid = 1'b1;
    signed_mode = sm;
    scalar = s;
    in_vector = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scalar = ~s;
    in_vector = ~v;
    signed_mode = ~sm;
    wait_out0(k);
    chk({tag, "_lat"}, k, 4);
    chk({tag, "_vld1"}, out_valid1, 1);
    chk({tag, "_vec0"}, out_vec0, e0);
    chk({tag, "_vec1"}, out_vec1, e1);
    chk({tag, "_ovf0"}, ovf0, eo);
    chk({tag, "_ovf1"}, ovf1, eo);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid0, 0);
  endtask

  function automatic void model16(input logic sm,
                                  input logic [15:0] s,
                                  input logic [63:0] v,
                                  output logic [63:0] r,
                                  output logic o);
    longint a, b, p, lo, hi;
    logic [15:0] ua;
    logic signed [15:0] sa, sb;
    o = 1'b0;
    r = '0;
    sb = s;
    b = sm ? longint'(sb) : longint'(s);
    lo = sm ? -32768 : 0;
    hi = sm ? 32767 : 65535;
    for (int i = 0; i < 4; i++) begin
      ua = v[i*16 +: 16];
      sa = ua;
      a = sm ? longint'(sa) : longint'(ua);
      p = a * b;
      if (p > hi || p < lo) begin
        o = 1'b1;
        r[i*16 +: 16] = (p < 0) ? 16'h8000 : 16'(hi);
      end else begin
        r[i*16 +: 16] = p[15:0];
      end
    end
  endfunction

  initial begin
    int k;
    logic seen;
    logic [63:0] er;
    logic eo2;

    #12;
    chk("rst_rdy", in_ready0, 1);
    chk("rst_vld", out_valid0, 0);
    chk("rst_vec", out_vec0, 0);
    chk("rst_ovf", ovf0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec("uns", 1'b0, 32'h10,
      {32'h56839f3a, 32'h5d3bb349, 32'h01d3a5b1, 32'he5780056,
       32'h11223344, 32'h99887766, 32'h44556677, 32'h55667788},
      {32'h6839f3a0, 32'hd3bb3490, 32'h1d3a5b10, 32'h57800560,
       32'h12233440, 32'h98877660, 32'h45566770, 32'h56677880},
      {32'hffffffff, 32'hffffffff, 32'h1d3a5b10, 32'hffffffff,
       32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff},
      1'b1);

    run_vec("sgn", 1'b1, 32'hffffffff, {8{32'h2}},
      {8{32'hfffffffe}}, {8{32'hfffffffe}}, 1'b0);

    run_vec("sgn_min", 1'b1, 32'hffffffff,
      {{4{32'h2}}, 32'h80000000, {3{32'h2}}},
      {{4{32'hfffffffe}}, 32'h80000000, {3{32'hfffffffe}}},
      {{4{32'hfffffffe}}, 32'h7fffffff, {3{32'hfffffffe}}},
      1'b1);

    run_vec("usat", 1'b0, 32'h00010000,
      {{7{32'h1}}, 32'h00020000},
      {{7{32'h00010000}}, 32'h0},
      {{7{32'h00010000}}, 32'hffffffff},
      1'b1);

    run_vec("zero", 1'b1, 32'h0,
      {32'h80000000, 32'h7fffffff, {6{32'h12345678}}},
      '0, '0, 1'b0);

    // backpressure with a second operand set waiting
    in_valid = 1'b1;
    signed_mode = 1'b0;
    scalar = 32'd2;
    in_vector = {8{32'd3}};
    @(posedge clk); #1;
    scalar = 32'd3;
    in_vector = {8{32'd5}};
    signed_mode = 1'b1;
    wait_out0(k);
    chk("bp_lat", k, 4);
    for (int c = 0; c < 5; c++) begin
      chk("bp_vec", out_vec0, {8{32'd6}});
      chk("bp_ovf", ovf0, 0);
      chk("bp_rdy", in_ready0, 0);
      chk("bp_vld", out_valid0, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_rdy", in_ready0, 1);
    chk("bp_idle_vld", out_valid0, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_acc2", in_ready0, 0);
    wait_out0(k);
    chk("bp2_lat", k, 4);
    chk("bp2_vec", out_vec0, {8{32'd15}});
    chk("bp2_ovf", ovf0, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset two cycles into COMPUTE
    in_valid = 1'b1;
    signed_mode = 1'b0;
    scalar = 32'h7;
    in_vector = {8{32'h11111111}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rc_rdy", in_ready0, 1);
    chk("rc_vld", out_valid0, 0);
    chk("rc_vec", out_vec0, 0);
    chk("rc_ovf", ovf0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid0) seen = 1'b1;
    end
    chk("rc_nopulse", seen, 0);

    run_vec("one", 1'b1, 32'h1,
      {32'h80000000, 32'hffffffff, 32'h7fffffff, 32'h0,
       32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h5a5a5a5a},
      {32'h80000000, 32'hffffffff, 32'h7fffffff, 32'h0,
       32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h5a5a5a5a},
      {32'h80000000, 32'hffffffff, 32'h7fffffff, 32'h0,
       32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'h5a5a5a5a},
      1'b0);

    // fully parallel 4x16 instance against the range-based model
    for (int i = 0; i < 1000; i++) begin
      sm2 = i[0];
      sc2 = 16'($urandom);
      if (i % 4 == 0) sc2 = 16'($urandom_range(0, 3));
      if (i % 8 == 1) sc2 = 16'hffff;
      vec2 = {$urandom, $urandom};
      if (i % 16 == 3) vec2[15:0] = 16'h8000;
      model16(sm2, sc2, vec2, er, eo2);
      chk("p_rdy", ir2, 1);
      iv2 = 1'b1;
      @(posedge clk); #1;
      iv2 = 1'b0;
      sc2 = ~sc2;
      vec2 = ~vec2;
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!ov2 && k < 20);
      chk("p_lat", k, 1);
      chk("p_vec", ovec2, er);
      chk("p_ovf", ovf2, eo2);
      or2 = 1'b1;
      @(posedge clk); #1;
      or2 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_multiplier_v_seq.md
Name: scalar_multiplier_v_seq

Overview:
Parametrised, time-multiplexed successor to the combinational scalar-vector multiplier. It multiplies every lane of a packed LANES x ELEM_W vector by one ELEM_W scalar. Only MULS hardware multipliers are used, shared over LANES/MULS cycles. Added features: signed/unsigned mode, optional saturation, a per-vector overflow flag, and valid/ready handshakes on input and output. It sits between the vector operand buffer and the XNOR/binary-connect scaling stage.

Parameters:
ELEM_W, 32, element and scalar width in bits
LANES, 8, number of vector lanes (lane i = in_vector[i*ELEM_W +: ELEM_W])
MULS, 2, multipliers instantiated; LANES % MULS must be 0, else elaboration error
SATURATE, 0, 0 = truncate to low ELEM_W bits; 1 = clamp to representable range

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
signed_mode  input  1  1 = two's-complement operands; sampled with operands
scalar  input  ELEM_W  scalar multiplier
in_vector  input  LANES*ELEM_W  packed input vector
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_vector  output  LANES*ELEM_W  packed result vector
overflow  output  1  at least one lane's full product did not fit in ELEM_W

Behaviour:
- Reset, asynchronous on rst high: state = IDLE, in_ready = 1, out_valid = 0, out_vector = 0, overflow = 0, lane counter = 0.
- States: IDLE, COMPUTE, DONE.
- IDLE: in_ready = 1. When in_valid & in_ready, register scalar, in_vector and signed_mode, clear the overflow accumulator, clear the lane counter, and go to COMPUTE.
- COMPUTE: in_ready = 0. Each cycle, lanes cnt*MULS .. cnt*MULS+MULS-1 are multiplied as a full 2*ELEM_W product, written to the result register, and OR-ed into the overflow accumulator. cnt increments each cycle. After the cycle with cnt = LANES/MULS-1, go to DONE.
- DONE: out_valid = 1, in_ready = 0. out_vector and overflow stay stable until out_valid & out_ready. On that edge, go to IDLE; out_valid drops and in_ready rises in the next cycle. There is no same-cycle bypass from output handshake to input accept.
- Latency: operands accepted at edge T; out_valid is high from edge T + LANES/MULS. Defaults give 4 cycles. Maximum throughput is one vector per LANES/MULS + 2 cycles.
- Unsigned overflow: upper ELEM_W bits of the product are nonzero.
- Signed overflow: upper ELEM_W+1 bits of the product are not all equal.
- Truncate (SATURATE = 0): the result is the low ELEM_W bits, regardless of overflow.
- Saturate (SATURATE = 1), on a lane that overflows:
  - unsigned clamps to all ones;
  - signed clamps to 0x7F..F if the true product is positive, 0x80..0 if negative.
- overflow is the OR over all lanes of the current vector. It is valid only while out_valid = 1 and keeps its value until the next accept.
- in_valid is ignored while in COMPUTE or DONE. Inputs do not need to be held after the accept edge.
- out_vector keeps its last value after the output handshake and is not cleared.
- Reset asserted mid-COMPUTE or in DONE: the operation is aborted and no out_valid pulse occurs for the aborted vector. After release, the block is in IDLE.
- Scalar 0: all lanes are 0, overflow = 0. Scalar 1: out_vector equals in_vector, overflow = 0.

Test Plan:
- Defaults, unsigned. scalar = 0x10, in_vector = {56839f3a, 5d3bb349, 01d3a5b1, e5780056, 11223344, 99887766, 44556677, 55667788}. Required: out_vector = {6839f3a0, d3bb3490, 1d3a5b10, 57800560, 12233440, 98877660, 45566770, 56677880}, overflow = 1, out_valid rises exactly 4 cycles after the accept edge.
- Signed mode, scalar = 0xFFFFFFFF, all lanes 0x00000002: every lane 0xFFFFFFFE, overflow = 0. Then with lane 3 = 0x80000000: SATURATE = 0 gives lane 3 = 0x80000000 and overflow = 1; SATURATE = 1 gives lane 3 = 0x7FFFFFFF and overflow = 1.
- Unsigned saturate: scalar = 0x00010000, lane 0 = 0x00020000, other lanes 0x1. Required: lane 0 = 0xFFFFFFFF, other lanes 0x00010000, overflow = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with new data. Required: out_vector/overflow stable, in_ready = 0, no second accept; after out_ready = 1, the next vector is accepted one cycle after IDLE is re-entered.
- Reset in COMPUTE: assert rst 2 cycles after accept. Required: immediate in_ready = 1, out_valid = 0, out_vector = 0. A new vector with scalar = 1 then returns identical lanes with overflow = 0.
- Parameter sweep: LANES = 4, MULS = 4, ELEM_W = 16. Required: latency of 1 cycle, and randomised results matching a reference model over 1000 vectors in both modes.
